// File: rtl/tile_map_writer.sv
// tile_map_writer
//   Writable 6-row x 8-column map of 2-bit tile types for the VGA playfield.
//   The whole map can be refilled from one of four built-in level patterns,
//   one cell per clock. Game logic can overwrite single cells through a
//   req/ack handshake. The drawer reads any cell combinationally.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   level_load in   start a level fill (sampled only in IDLE)
//   level_sel  in   [1:0] level pattern, captured with level_load
//   wr_req     in   single-cell write request, held until wr_ack
//   wr_Xnum    in   [2:0] write column
//   wr_Ynum    in   [2:0] write row (6/7 rejected with wr_err)
//   wr_type    in   [1:0] tile type to write
//   wr_ack     out  one-cycle acknowledge of a serviced write
//   wr_err     out  with wr_ack: row out of range, nothing written
//   busy       out  level fill in progress
//   load_done  out  one-cycle pulse when a fill completes
//   Xnum       in   [2:0] read column
//   Ynum       in   [2:0] read row
//   Tile_Type  out  [1:0] cell (Ynum, Xnum); 2'b00 for rows 6/7
module tile_map_writer (
    input  logic       clk,
    input  logic       reset,
    input  logic       level_load,
    input  logic [1:0] level_sel,
    input  logic       wr_req,
    input  logic [2:0] wr_Xnum,
    input  logic [2:0] wr_Ynum,
    input  logic [1:0] wr_type,
    output logic       wr_ack,
    output logic       wr_err,
    output logic       busy,
    output logic       load_done,
    input  logic [2:0] Xnum,
    input  logic [2:0] Ynum,
    output logic [1:0] Tile_Type
);

    localparam logic [5:0] LastIdx = 6'd47;

    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [1:0] sel_q, sel_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       done_q, done_d;

    // Single map write port shared by the fill sequencer and the cell writer.
    logic       we;
    logic [5:0] waddr;
    logic [1:0] wdata;

    logic [1:0] map_q [48];

    function automatic logic [1:0] pattern(input logic [1:0] sel, input logic [2:0] y,
                                           input logic [2:0] x);
        logic [1:0] t;
        t = 2'b00;
        case (sel)
            2'd0: if (y == 3'd5 && x <= 3'd5) t = 2'b01;
            2'd1: begin
                if (y == 3'd5) t = 2'b01;
                else if (y == 3'd3 && x >= 3'd2 && x <= 3'd5) t = 2'b10;
            end
            2'd2: begin
                if (y == 3'd5) t = 2'b01;
                else if (y == 3'd4 && x[0]) t = 2'b11;
            end
            default: t = 2'b00;
        endcase
        return t;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        done_d  = 1'b0;
        we      = 1'b0;
        waddr   = idx_q;
        wdata   = 2'b00;
        case (state_q)
            StIdle: begin
                if (level_load) begin
                    // Load wins; a simultaneous write stays pending.
                    state_d = StLoad;
                    sel_d   = level_sel;
                    idx_d   = 6'd0;
                end else if (wr_req && !ack_q) begin
                    // ack_q gate stops a held request being serviced twice.
                    ack_d = 1'b1;
                    if (wr_Ynum > 3'd5) begin
                        err_d = 1'b1;
                    end else begin
                        we    = 1'b1;
                        waddr = {wr_Ynum, wr_Xnum};
                        wdata = wr_type;
                    end
                end
            end
            StLoad: begin
                we    = 1'b1;
                waddr = idx_q;
                wdata = pattern(sel_q, idx_q[5:3], idx_q[2:0]);
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = 6'd0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 6'd0;
            sel_q   <= 2'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 48; i++) map_q[i] <= 2'b00;
        end else if (we) begin
            map_q[waddr] <= wdata;
        end
    end

    assign wr_ack    = ack_q;
    assign wr_err    = err_q;
    assign busy      = (state_q == StLoad);
    assign load_done = done_q;
    assign Tile_Type = (Ynum > 3'd5) ? 2'b00 : map_q[{Ynum, Xnum}];

endmodule

// File: tb/tb_tile_map_writer.sv
`timescale 1ns/1ps
module tb_tile_map_writer;

    logic       clk;
    logic       reset;
    logic       level_load;
    logic [1:0] level_sel;
    logic       wr_req;
    logic [2:0] wr_Xnum;
    logic [2:0] wr_Ynum;
    logic [1:0] wr_type;
    logic       wr_ack;
    logic       wr_err;
    logic       busy;
    logic       load_done;
    logic [2:0] Xnum;
    logic [2:0] Ynum;
    logic [1:0] Tile_Type;

    tile_map_writer dut (
        .clk       (clk),
        .reset     (reset),
        .level_load(level_load),
        .level_sel (level_sel),
        .wr_req    (wr_req),
        .wr_Xnum   (wr_Xnum),
        .wr_Ynum   (wr_Ynum),
        .wr_type   (wr_type),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .busy      (busy),
        .load_done (load_done),
        .Xnum      (Xnum),
        .Ynum      (Ynum),
        .Tile_Type (Tile_Type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected wr_err per write ack, and number of load_done pulses owed.
    bit exp_err_q[$];
    int done_exp = 0;
    int busy_cnt = 0;

    // Reference map, indexed [row][col].
    logic [1:0] model [6][8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] level_cell(input int lvl, input int y, input int x);
        if (lvl == 0) return (y == 5 && x <= 5) ? 2'b01 : 2'b00;
        if (lvl == 1) begin
            if (y == 5) return 2'b01;
            if (y == 3 && x >= 2 && x <= 5) return 2'b10;
            return 2'b00;
        end
        if (lvl == 2) begin
            if (y == 5) return 2'b01;
            if (y == 4 && (x % 2) == 1) return 2'b11;
            return 2'b00;
        end
        return 2'b00;
    endfunction

    task automatic model_level(input int lvl);
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++) model[y][x] = level_cell(lvl, y, x);
    endtask

    task automatic sweep(input string tag);
        logic [1:0] e;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                Xnum = 3'(x);
                Ynum = 3'(y);
                #1;
                e = (y < 6) ? model[y][x] : 2'b00;
                check($sformatf("%s_y%0d_x%0d", tag, y, x), {6'd0, Tile_Type}, {6'd0, e});
            end
        end
    endtask

    // Issue one write, holding wr_req through the ack cycle.
    task automatic do_write(input int y, input int x, input logic [1:0] t);
        wr_Ynum = 3'(y);
        wr_Xnum = 3'(x);
        wr_type = t;
        wr_req  = 1'b1;
        exp_err_q.push_back(y > 5);
        if (y < 6) model[y][x] = t;
        @(posedge clk); #1;
        check("wr_ack_latency", {7'd0, wr_ack}, 8'd1);
        @(posedge clk); #1;
        check("wr_ack_single", {7'd0, wr_ack}, 8'd0);
        wr_req = 1'b0;
    endtask

    task automatic do_load(input int lvl);
        int got;
        level_sel  = 2'(lvl);
        level_load = 1'b1;
        done_exp++;
        model_level(lvl);
        @(posedge clk); #1;
        level_load = 1'b0;
        level_sel  = 2'($urandom);
        check("busy_after_req", {7'd0, busy}, 8'd1);
        got = -1;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) level_load = 1'b1;   // ignored during fill
            @(posedge clk); #1;
            level_load = 1'b0;
            if (load_done) begin
                got = c;
                break;
            end
        end
        check("load_done_cycle", 8'(got), 8'd48);
        check("busy_after_done", {7'd0, busy}, 8'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an ack or done pulse.
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (wr_ack) begin
                    if (exp_err_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_wr_ack: got 1 expected 0 at %0t", $time);
                    end else begin
                        e = exp_err_q.pop_front();
                        check("wr_err", {7'd0, wr_err}, {7'd0, e});
                    end
                end else begin
                    check("wr_err_idle", {7'd0, wr_err}, 8'd0);
                end
                if (busy) busy_cnt++;
                if (load_done) begin
                    if (done_exp == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_load_done: got 1 expected 0 at %0t", $time);
                    end else begin
                        done_exp--;
                        check("busy_cycles", 8'(busy_cnt), 8'd48);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        reset      = 1'b1;
        level_load = 1'b0;
        level_sel  = 2'd0;
        wr_req     = 1'b0;
        wr_Xnum    = 3'd0;
        wr_Ynum    = 3'd0;
        wr_type    = 2'd0;
        Xnum       = 3'd0;
        Ynum       = 3'd0;
        model_level(3);

        // Reset and read
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_ack", {7'd0, wr_ack}, 8'd0);
        check("rst_done", {7'd0, load_done}, 8'd0);
        check("rst_err", {7'd0, wr_err}, 8'd0);
        sweep("rst");

        // Level 0 load
        do_load(0);
        sweep("lvl0");

        // Single write held through ack, then out-of-range writes
        do_write(2, 7, 2'b11);
        sweep("wr27");
        do_write(6, 3, 2'b10);
        do_write(7, 1, 2'b01);
        sweep("oor");

        // Collision: load and write on the same edge
        level_sel  = 2'd1;
        level_load = 1'b1;
        wr_Ynum    = 3'd0;
        wr_Xnum    = 3'd0;
        wr_type    = 2'b10;
        wr_req     = 1'b1;
        done_exp++;
        exp_err_q.push_back(1'b0);
        model_level(1);
        model[0][0] = 2'b10;
        @(posedge clk); #1;
        level_load = 1'b0;
        got = -1;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            if (wr_ack) begin
                got = c;
                break;
            end
        end
        wr_req = 1'b0;
        check("collision_ack_cycle", 8'(got), 8'd49);
        @(posedge clk); #1;
        sweep("coll");

        // Reset mid-load
        level_sel  = 2'd2;
        level_load = 1'b1;
        @(posedge clk); #1;
        level_load = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy", {7'd0, busy}, 8'd0);
        model_level(3);
        repeat (60) @(posedge clk);
        #1;
        sweep("midrst");

        // Randomized mix of loads and writes
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 2) do_load(int'($urandom_range(0, 3)));
            else do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          2'($urandom));
            sweep($sformatf("rnd%0d", i));
        end

        repeat (3) @(posedge clk);
        #1;
        check("acks_outstanding", 8'(exp_err_q.size()), 8'd0);
        check("dones_outstanding", 8'(done_exp), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_map_writer.md
# tile_map_writer

Writable 6-row × 8-column tile map for the VGA playfield. It holds the 2-bit tile type of every cell and fills the whole map from a selected built-in level pattern on request, one cell per clock. Game logic can overwrite a single cell through a request/acknowledge handshake, for example to remove a collected tile. The drawing logic reads any cell combinationally through the same `Xnum`/`Ynum` → `Tile_Type` lookup used by the static tile ROM, so either block can feed the tile drawer.

## Interface
Parameters: none; geometry fixed at 8 columns (X 0..7) × 6 rows (Y 0..5), 2-bit tile type.

- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `level_load`  in  1  request to fill the map from pattern `level_sel`; sampled only in IDLE
- `level_sel`  in  2  level pattern select, captured with `level_load`
- `wr_req`  in  1  single-cell write request; held high until `wr_ack`
- `wr_Xnum`  in  3  column of the write
- `wr_Ynum`  in  3  row of the write
- `wr_type`  in  2  tile type to write
- `wr_ack`  out  1  one-cycle acknowledge of a write request
- `wr_err`  out  1  valid with `wr_ack`; 1 = row out of range, no write performed
- `busy`  out  1  high while a level load is in progress
- `load_done`  out  1  one-cycle pulse when a level load completes
- `Xnum`  in  3  read column
- `Ynum`  in  3  read row
- `Tile_Type`  out  2  combinational read of cell (`Ynum`, `Xnum`); 2'b00 if `Ynum` > 5

## Operation
The block has two states, IDLE and LOAD. Cell index is `idx = Y*8 + X`, range 0..47, row-major.

Reset behaviour:
- Every cell is set to 2'b00 and the state goes to IDLE.
- `wr_ack`, `wr_err`, `busy` and `load_done` are all 0.
- The 6-bit index counter is 0.
- Reset during LOAD aborts the load. The map is cleared and no `load_done` is issued.

IDLE state:
- `level_load` = 1 moves the state to LOAD. It captures `level_sel` and sets `idx` to 0. Load takes priority: a `wr_req` presented in the same cycle is not serviced and stays pending.
- Otherwise, `wr_req` = 1 with `wr_ack` = 0 services one write:
  - If `wr_Ynum` ≤ 5, cell (`wr_Ynum`, `wr_Xnum`) takes `wr_type`.
  - If `wr_Ynum` is 6 or 7, no cell changes and `wr_err` is set.
- `wr_ack` is registered. It is high for exactly one cycle per serviced request.
- A request still high while `wr_ack` = 1 is not serviced again. A back-to-back write therefore needs `wr_req` to be sampled again after the ack cycle.

LOAD state:
- Each cycle, cell `idx` is written with `pattern(level_sel, Y, X)` and `idx` increments.
- After writing `idx` = 47, the state returns to IDLE and `load_done` pulses.
- `level_load` and `wr_req` are ignored during LOAD. `wr_req` remains pending and is serviced in IDLE.

Level patterns (cells not listed are 2'b00):
- Level 0: row 5, columns 0..5 = 2'b01.
- Level 1: row 5, all columns = 2'b01; row 3, columns 2..5 = 2'b10.
- Level 2: row 5, all columns = 2'b01; row 4, odd columns = 2'b11.
- Level 3: all cells 2'b00 (clear).

`Tile_Type` is a pure combinational mux of the current map contents. During LOAD it shows a partially rewritten map.

## Timing
- **Write latency:** `wr_req` sampled at edge N (IDLE) → cell updated at edge N → `wr_ack` (and `wr_err`) high from edge N to edge N+1. A read of that cell after edge N returns the new type.
- **Load latency:** `level_load` sampled at edge N → `busy` = 1 after edge N. Cell `idx` = k is written at edge N+1+k. At edge N+48: state returns to IDLE, `busy` = 0, `load_done` = 1 for one cycle.
- **Total load occupancy:** 48 cycles busy, 49 cycles including the request edge.
- **Earliest next request:** a write request pending during the load is serviced at edge N+49 at the earliest, when IDLE with `load_done` high.
- **`wr_err`:** only meaningful while `wr_ack` = 1; 0 otherwise.

## Test plan
- **Reset and read:** assert `reset` for 2 cycles, release → every (Y,X) read returns 2'b00; `busy`, `wr_ack`, `load_done` = 0.
- **Level 0 load:** pulse `level_load` with `level_sel` = 0 → `busy` high exactly 48 cycles, one `load_done` pulse. (5,0)..(5,5) read 2'b01; (5,6), (5,7), (0,0) read 2'b00.
- **Single write and hold:** in IDLE write (Y=2, X=7, type 2'b11) holding `wr_req` → exactly one `wr_ack` with `wr_err` = 0, the cycle after sampling; cell (2,7) reads 2'b11; no second ack while `wr_req` stays high through the ack cycle.
- **Out-of-range write:** write with `wr_Ynum` = 6 → `wr_ack` = 1 with `wr_err` = 1; all 48 cells unchanged.
- **Collision:** `level_load` (level 1) and `wr_req` (Y=0, X=0, type 2'b10) asserted on the same edge → load runs first; the write is acked at edge N+49. Final map is level 1 plus cell (0,0) = 2'b10.
- **Reset mid-load:** start level 2, assert `reset` at load cycle 20 → next cycle `busy` = 0, no `load_done`, all cells 2'b00.
